spi_cs_arbiter: RTL and testbench
=================================

# spi_cs_arbiter

Round-robin arbiter and transaction sequencer that shares one chip-select SPI master among NUM_REQ requesters. Each requester submits a complete CS transaction (byte count plus packed TX bytes); the arbiter grants one at a time, feeds bytes to the master over its TX_valid/TX_start handshake, collects RX bytes, and returns them with a done pulse. It sits between the client logic and the SPI_CS master, and both share one clock and reset.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- MAX_BYTES_PER_CS, 2, max bytes per transaction; must match the master
- TIMEOUT_CLKS, 1024, watchdog limit in system_clk cycles per transaction
- Derived: CW = $clog2(MAX_BYTES_PER_CS+1); IW = max(1, $clog2(NUM_REQ))

Ports:
- system_clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held until req_ready
- req_count  in  NUM_REQ*CW  byte count, requester i at [i*CW +: CW]
- req_tx_data  in  NUM_REQ*MAX_BYTES_PER_CS*8  TX bytes; byte 0 in the LSBs of each slice
- req_ready  out  NUM_REQ  one-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: bad count or timeout
- rsp_rx_data  out  MAX_BYTES_PER_CS*8  RX bytes, byte 0 in the LSBs; held until the next completion
- busy  out  1  transaction in progress
- grant_id  out  IW  current or last granted requester
- m_tx_count  out  CW  to master i_TX_Count
- m_tx_byte  out  8  to master TX_Byte
- m_tx_dv  out  1  to master TX_valid
- m_tx_ready  in  1  from master TX_start
- m_rx_dv  in  1  from master RX_valid
- m_rx_byte  in  8  from master RX_Byte
- m_cs_n  in  1  from master o_SPI_CS_n

## Operation
- States: IDLE, SEND, GAP, WAIT_RDY, WAIT_CS, DONE.
- **IDLE:**
  - Scan req_valid round-robin, starting at rr_ptr. rr_ptr = last grant + 1 mod NUM_REQ; it resets to 0.
  - On a winner: pulse req_ready[w]. Capture req_count[w] into m_tx_count and req_tx_data[w] into the TX buffer. Clear tx_idx, rx_idx, the watchdog and the RX buffer. Set grant_id=w and busy=1.
  - If the count is 0 or greater than MAX_BYTES_PER_CS, go to DONE with err=1 instead.
- **SEND:**
  - When m_tx_ready=1: drive m_tx_dv=1 for one cycle with m_tx_byte = buffer[tx_idx], increment tx_idx, then go to GAP.
- **GAP:** one cycle, ignoring m_tx_ready, because the master drops ready after valid.
- **WAIT_RDY:** wait for m_tx_ready=1.
  - If tx_idx < count, go to SEND.
  - Otherwise go to WAIT_CS.
- **RX capture:** in any non-IDLE state, m_rx_dv=1 writes m_rx_byte to rx_buf[rx_idx] and increments rx_idx. Writes are ignored once rx_idx == count.
- **WAIT_CS:** leave when rx_idx == count and m_cs_n == 1. A capture in the same cycle counts.
- **DONE:**
  - Pulse rsp_valid[grant_id] for one cycle. Drive rsp_err, and copy rx_buf to rsp_rx_data.
  - Update rr_ptr, clear busy, and return to IDLE.
- **Watchdog:** counts every cycle while busy. On reaching TIMEOUT_CLKS, abort to DONE with err=1; RX bytes received so far are returned and the rest are 0.
- m_tx_count holds its value between grants; it is only rewritten at a grant.
- Requests arriving while busy wait. req_valid deasserted before grant is simply not served.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rx_data=0, busy=0, grant_id=0, m_tx_count=0, m_tx_byte=0, m_tx_dv=0, rr_ptr=0, state=IDLE.
- Grant to first m_tx_dv: 1 cycle if m_tx_ready is already high.
- m_tx_dv is never high on two consecutive cycles. It is never asserted while m_tx_ready=0.
- req_ready and rsp_valid are registered single-cycle pulses.
- rsp_valid occurs at the earliest 1 cycle after m_cs_n rises with all bytes received.
- Back-to-back: the next grant can occur in the cycle after DONE. Minimum spacing between rsp_valid and the next req_ready is 1 cycle.
- Simultaneous req_valid: the lowest index at or above rr_ptr wins, wrapping around.
- Reset mid-transaction: on the next edge the state is IDLE and all outputs take their reset values. No rsp_valid is produced for the aborted request.

## Test plan
- **Single request, loopback:** MISO tied to MOSI, master SPI_MODE=3, CLKS_PER_HALF_BIT=4. Req0 count=2, data 0xC2C1 → one req_ready[0], two m_tx_dv pulses with bytes C1 then C2. Then rsp_valid[0], rsp_err=0, rsp_rx_data=0xC2C1.
- **Contention:** req0 (0xB2A1) and req1 (0x3355) asserted in the same cycle after reset → req0 served first, then req1. A second simultaneous pair is served req1 first (round-robin), and each returns its own data.
- **Bad count:** req1 count=0, then count=3 → req_ready[1] then rsp_valid[1] with rsp_err=1 and no m_tx_dv.
- **Timeout:** master model never raises m_tx_ready, TIMEOUT_CLKS=64 → rsp_valid[0] with rsp_err=1 exactly 64 busy cycles after grant.
- **Reset mid-transfer:** assert reset one cycle after the first m_tx_dv → all outputs at reset values the next cycle, with no rsp_valid. A fresh req0 count=1, data 0x7E then completes with 0x7E.
- **Single-byte transaction:** req0 count=1, data 0x5A → m_tx_count=1, exactly one m_tx_dv, and rsp_valid only after m_cs_n returns high.

Source files
------------

// File: rtl/spi_cs_arbiter_if.sv
// rtl/spi_cs_arbiter_if.sv - link between the CS arbiter and the single-CS SPI master
//
// Purpose: bundles the byte handshake between the arbiter and the SPI master.
// Ports (signals):
//   m_tx_count  arbiter -> master  byte count for the current CS transaction
//   m_tx_byte   arbiter -> master  byte to transmit
//   m_tx_dv     arbiter -> master  one-cycle strobe for m_tx_byte
//   m_tx_ready  master -> arbiter  master can accept the next byte
//   m_rx_dv     master -> arbiter  one-cycle strobe for m_rx_byte
//   m_rx_byte   master -> arbiter  received byte
//   m_cs_n      master -> arbiter  chip select, active low
// Modports: master = arbiter side (drives TX), slave = SPI master side.

interface spi_cs_arbiter_if #(
    parameter int CW = 2
);
    logic [CW-1:0] m_tx_count;
    logic [7:0]    m_tx_byte;
    logic          m_tx_dv;
    logic          m_tx_ready;
    logic          m_rx_dv;
    logic [7:0]    m_rx_byte;
    logic          m_cs_n;

    modport master (
        output m_tx_count, m_tx_byte, m_tx_dv,
        input  m_tx_ready, m_rx_dv, m_rx_byte, m_cs_n
    );

    modport slave (
        input  m_tx_count, m_tx_byte, m_tx_dv,
        output m_tx_ready, m_rx_dv, m_rx_byte, m_cs_n
    );
endinterface

// File: rtl/spi_cs_arbiter.sv
// rtl/spi_cs_arbiter.sv - round-robin arbiter sharing one single-CS SPI master
//
// Purpose: grants one requester at a time, streams its TX bytes to the SPI
// master, collects the RX bytes and returns them with a one-cycle done pulse.
// Ports:
//   system_clk, reset   clock, synchronous active-high reset
//   req_valid/req_count/req_tx_data/req_ready   per-requester submit side
//   rsp_valid/rsp_err/rsp_rx_data               per-requester completion side
//   busy, grant_id                               status
//   m_if                                         SPI master link (master modport)

module spi_cs_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int TIMEOUT_CLKS     = 1024,
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1),
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int DW = MAX_BYTES_PER_CS * 8
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*CW-1:0] req_count,
    input  logic [NUM_REQ*DW-1:0] req_tx_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [DW-1:0]         rsp_rx_data,
    output logic                  busy,
    output logic [IW-1:0]         grant_id,
    spi_cs_arbiter_if.master      m_if
);
    localparam int WW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_GAP, S_WAIT_RDY, S_WAIT_CS, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DW-1:0]        tx_buf_q, tx_buf_d;
    logic [DW-1:0]        rx_buf_q, rx_buf_d;
    logic [CW-1:0]        tx_idx_q, tx_idx_d;
    logic [CW-1:0]        rx_idx_q, rx_idx_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DW-1:0]        rsp_rx_data_q, rsp_rx_data_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 tx_dv_q, tx_dv_d;

    logic                 win_found;
    logic [IW-1:0]        win_id;
    logic [IW-1:0]        cand;

    // Walk offsets from the far end down so the lowest offset from rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        count_d       = count_q;
        tx_buf_d      = tx_buf_q;
        rx_buf_d      = rx_buf_q;
        tx_idx_d      = tx_idx_q;
        rx_idx_d      = rx_idx_q;
        wd_d          = wd_q;
        err_d         = err_q;
        busy_d        = busy_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_err_d     = rsp_err_q;
        rsp_rx_data_d = rsp_rx_data_q;
        tx_byte_d     = tx_byte_q;
        tx_dv_d       = 1'b0;

        // RX capture runs independently of the TX sequencing states.
        if (state_q != S_IDLE && m_if.m_rx_dv && rx_idx_q < count_q) begin
            rx_buf_d[int'(rx_idx_q)*8 +: 8] = m_if.m_rx_byte;
            rx_idx_d = rx_idx_q + CW'(1);
        end

        if (state_q != S_IDLE && state_q != S_DONE) begin
            wd_d = wd_q + WW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready_d[win_id] = 1'b1;
                    count_d  = req_count[int'(win_id)*CW +: CW];
                    tx_buf_d = req_tx_data[int'(win_id)*DW +: DW];
                    rx_buf_d = '0;
                    tx_idx_d = '0;
                    rx_idx_d = '0;
                    wd_d     = '0;
                    grant_d  = win_id;
                    busy_d   = 1'b1;
                    if (count_d == '0 || count_d > MAX_CNT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (m_if.m_tx_ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = tx_buf_q[int'(tx_idx_q)*8 +: 8];
                    tx_idx_d  = tx_idx_q + CW'(1);
                    state_d   = S_GAP;
                end
            end
            // The master only drops ready after seeing valid, so ready is stale here.
            S_GAP: state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (m_if.m_tx_ready) begin
                    state_d = (tx_idx_q < count_q) ? S_SEND : S_WAIT_CS;
                end
            end
            S_WAIT_CS: begin
                if (rx_idx_d == count_q && m_if.m_cs_n) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid_d[grant_q] = 1'b1;
                rsp_err_d     = err_q;
                rsp_rx_data_d = rx_buf_q;
                rr_ptr_d      = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The DONE cycle is the last of the TIMEOUT_CLKS busy cycles.
        if (state_q != S_IDLE && state_q != S_DONE && wd_d == WD_LAST) begin
            err_d   = 1'b1;
            tx_dv_d = 1'b0;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            count_q       <= '0;
            tx_buf_q      <= '0;
            rx_buf_q      <= '0;
            tx_idx_q      <= '0;
            rx_idx_q      <= '0;
            wd_q          <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_rx_data_q <= '0;
            tx_byte_q     <= '0;
            tx_dv_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            count_q       <= count_d;
            tx_buf_q      <= tx_buf_d;
            rx_buf_q      <= rx_buf_d;
            tx_idx_q      <= tx_idx_d;
            rx_idx_q      <= rx_idx_d;
            wd_q          <= wd_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rx_data_q <= rsp_rx_data_d;
            tx_byte_q     <= tx_byte_d;
            tx_dv_q       <= tx_dv_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_rx_data     = rsp_rx_data_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;
    assign m_if.m_tx_count = count_q;
    assign m_if.m_tx_byte  = tx_byte_q;
    assign m_if.m_tx_dv    = tx_dv_q;
endmodule

// File: tb/tb_spi_cs_arbiter.sv
// tb/tb_spi_cs_arbiter.sv - directed self-checking bench for spi_cs_arbiter

module tb_spi_cs_arbiter;
    localparam int NUM_REQ   = 2;
    localparam int MAXB      = 2;
    localparam int TMO       = 64;
    localparam int CW        = $clog2(MAXB + 1);
    localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW        = MAXB * 8;
    localparam int BYTE_CLKS = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*CW-1:0] req_count;
    logic [NUM_REQ*DW-1:0] req_tx_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic                  rsp_err;
    logic [DW-1:0]         rsp_rx_data;
    logic                  busy;
    logic [IW-1:0]         grant_id;

    spi_cs_arbiter_if #(.CW(CW)) m_if ();

    spi_cs_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_BYTES_PER_CS(MAXB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .system_clk (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_count  (req_count),
        .req_tx_data(req_tx_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rx_data(rsp_rx_data),
        .busy       (busy),
        .grant_id   (grant_id),
        .m_if       (m_if)
    );

    // Behavioral single-CS SPI master in loopback.
    logic       mdl_ready, mdl_cs_n, mdl_rx_dv, mdl_stall;
    logic [7:0] mdl_byte, mdl_rx_byte;
    int         mdl_timer, mdl_left, mdl_hold;

    assign m_if.m_tx_ready = mdl_ready & ~mdl_stall;
    assign m_if.m_rx_dv    = mdl_rx_dv;
    assign m_if.m_rx_byte  = mdl_rx_byte;
    assign m_if.m_cs_n     = mdl_cs_n;

    always @(posedge clk) begin
        if (reset) begin
            mdl_ready   <= 1'b1;
            mdl_cs_n    <= 1'b1;
            mdl_rx_dv   <= 1'b0;
            mdl_rx_byte <= 8'h00;
            mdl_byte    <= 8'h00;
            mdl_timer   <= 0;
            mdl_left    <= 0;
            mdl_hold    <= 0;
        end else begin
            mdl_rx_dv <= 1'b0;
            if (m_if.m_tx_dv && m_if.m_tx_ready) begin
                mdl_ready <= 1'b0;
                mdl_cs_n  <= 1'b0;
                mdl_byte  <= m_if.m_tx_byte;
                mdl_timer <= BYTE_CLKS;
                if (mdl_cs_n) mdl_left <= int'(m_if.m_tx_count);
            end else if (mdl_timer != 0) begin
                mdl_timer <= mdl_timer - 1;
                if (mdl_timer == 1) begin
                    mdl_rx_dv   <= 1'b1;
                    mdl_rx_byte <= mdl_byte;
                    mdl_left    <= mdl_left - 1;
                    if (mdl_left > 1) mdl_ready <= 1'b1;
                    else mdl_hold <= 3;
                end
            end else if (mdl_hold != 0) begin
                mdl_hold <= mdl_hold - 1;
                if (mdl_hold == 1) begin
                    mdl_cs_n  <= 1'b1;
                    mdl_ready <= 1'b1;
                end
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int tx_q[$], dv_cyc_q[$], gnt_q[$], rdy_cyc_q[$];
    int rsp_id_q[$], rsp_err_q[$], rsp_dat_q[$], rsp_cyc_q[$], rsp_cs_q[$];
    int cyc = 0;
    int viol = 0;
    int cs_rise_cyc = 1 << 30;
    logic prev_dv = 1'b0;
    logic prev_cs = 1'b1;
    logic [NUM_REQ-1:0] mon_sh;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_if.m_tx_dv) begin
            tx_q.push_back(int'(m_if.m_tx_byte));
            dv_cyc_q.push_back(cyc);
            if (prev_dv || !m_if.m_tx_ready) viol = viol + 1;
        end
        prev_dv = m_if.m_tx_dv;
        if (m_if.m_cs_n && !prev_cs) cs_rise_cyc = cyc;
        prev_cs = m_if.m_cs_n;
        for (int i = 0; i < NUM_REQ; i++) begin
            mon_sh = req_ready >> i;
            if (mon_sh[0]) begin
                gnt_q.push_back(i);
                rdy_cyc_q.push_back(cyc);
            end
            mon_sh = rsp_valid >> i;
            if (mon_sh[0]) begin
                rsp_id_q.push_back(i);
                rsp_err_q.push_back(int'(rsp_err));
                rsp_dat_q.push_back(int'(rsp_rx_data));
                rsp_cyc_q.push_back(cyc);
                rsp_cs_q.push_back(int'(m_if.m_cs_n));
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        tx_q.delete();
        dv_cyc_q.delete();
        gnt_q.delete();
        rdy_cyc_q.delete();
        rsp_id_q.delete();
        rsp_err_q.delete();
        rsp_dat_q.delete();
        rsp_cyc_q.delete();
        rsp_cs_q.delete();
        viol = 0;
        cs_rise_cyc = 1 << 30;
    endtask

    task automatic post(input int i, input int cnt, input logic [DW-1:0] dat);
        req_count[i*CW +: CW]   = CW'(cnt);
        req_tx_data[i*DW +: DW] = dat;
        req_valid = req_valid | (NUM_REQ'(1) << i);
    endtask

    task automatic run(input int n_rsp, input int budget, input string tag);
        int t;
        t = 0;
        while (rsp_id_q.size() < n_rsp && t < budget) begin
            tick();
            t = t + 1;
            req_valid = req_valid & ~req_ready;
        end
        check({tag, "_rsp_count"}, rsp_id_q.size(), n_rsp);
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        req_valid   = '0;
        req_count   = '0;
        req_tx_data = '0;
        mdl_stall   = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_pulses", {req_ready, rsp_valid}, 0);
        check("rst_tx_count", m_if.m_tx_count, 0);
        check("rst_tx_dv", m_if.m_tx_dv, 0);
        check("rst_tx_byte", m_if.m_tx_byte, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_rsp", {rsp_err, rsp_rx_data}, 0);
        reset = 1'b0;
        tick();

        // Single 2-byte request, loopback
        clr_mon();
        post(0, 2, 16'hC2C1);
        run(1, 200, "t1");
        check("t1_ngrant", gnt_q.size(), 1);
        check("t1_grant0", qget(gnt_q, 0), 0);
        check("t1_ntx", tx_q.size(), 2);
        check("t1_tx0", qget(tx_q, 0), 32'hC1);
        check("t1_tx1", qget(tx_q, 1), 32'hC2);
        check("t1_latency", qget(dv_cyc_q, 0) - qget(rdy_cyc_q, 0), 1);
        check("t1_id", qget(rsp_id_q, 0), 0);
        check("t1_err", qget(rsp_err_q, 0), 0);
        check("t1_data", qget(rsp_dat_q, 0), 32'hC2C1);
        check("t1_after_cs", qget(rsp_cyc_q, 0) > cs_rise_cyc, 1);
        check("t1_proto", viol, 0);

        // Contention right after reset: req0 before req1
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        clr_mon();
        post(0, 2, 16'hB2A1);
        post(1, 2, 16'h3355);
        run(2, 300, "t2");
        check("t2_first", qget(gnt_q, 0), 0);
        check("t2_second", qget(gnt_q, 1), 1);
        check("t2_rsp_id0", qget(rsp_id_q, 0), 0);
        check("t2_rsp_id1", qget(rsp_id_q, 1), 1);
        check("t2_data0", qget(rsp_dat_q, 0), 32'hB2A1);
        check("t2_data1", qget(rsp_dat_q, 1), 32'h3355);
        check("t2_errs", qget(rsp_err_q, 0) + qget(rsp_err_q, 1), 0);
        check("t2_grant_id", grant_id, 1);
        check("t2_proto", viol, 0);

        // Single-byte transaction; upper byte must not be sent
        clr_mon();
        post(0, 1, 16'hEE5A);
        run(1, 200, "t3");
        check("t3_tx_count", m_if.m_tx_count, 1);
        check("t3_ntx", tx_q.size(), 1);
        check("t3_tx0", qget(tx_q, 0), 32'h5A);
        check("t3_data", qget(rsp_dat_q, 0), 32'h005A);
        check("t3_err", qget(rsp_err_q, 0), 0);
        check("t3_cs_high", qget(rsp_cs_q, 0), 1);
        check("t3_after_cs", qget(rsp_cyc_q, 0) > cs_rise_cyc, 1);

        // Bad counts on requester 1
        clr_mon();
        post(1, 0, 16'hFFFF);
        run(1, 50, "t5a");
        check("t5a_grant", qget(gnt_q, 0), 1);
        check("t5a_id", qget(rsp_id_q, 0), 1);
        check("t5a_err", qget(rsp_err_q, 0), 1);
        check("t5a_ntx", tx_q.size(), 0);
        check("t5a_spacing", qget(rsp_cyc_q, 0) - qget(rdy_cyc_q, 0), 1);
        check("t5a_data", qget(rsp_dat_q, 0), 0);
        clr_mon();
        post(1, 3, 16'hABCD);
        run(1, 50, "t5b");
        check("t5b_id", qget(rsp_id_q, 0), 1);
        check("t5b_err", qget(rsp_err_q, 0), 1);
        check("t5b_ntx", tx_q.size(), 0);
        check("t5b_tx_count", m_if.m_tx_count, 3);

        // Watchdog: master never ready
        mdl_stall = 1'b1;
        clr_mon();
        post(0, 2, 16'h1234);
        run(1, 200, "t6");
        check("t6_id", qget(rsp_id_q, 0), 0);
        check("t6_err", qget(rsp_err_q, 0), 1);
        check("t6_timeout", qget(rsp_cyc_q, 0) - qget(rdy_cyc_q, 0), TMO);
        check("t6_ntx", tx_q.size(), 0);
        check("t6_data", qget(rsp_dat_q, 0), 0);
        mdl_stall = 1'b0;
        tick();

        // Second simultaneous pair: pointer now favours req1
        clr_mon();
        post(0, 2, 16'h6B4C);
        post(1, 2, 16'h0F9E);
        run(2, 300, "t4");
        check("t4_first", qget(gnt_q, 0), 1);
        check("t4_second", qget(gnt_q, 1), 0);
        check("t4_data1", qget(rsp_dat_q, 0), 32'h0F9E);
        check("t4_data0", qget(rsp_dat_q, 1), 32'h6B4C);
        check("t4_grant_id", grant_id, 0);
        check("t4_proto", viol, 0);

        // Reset one cycle after the first m_tx_dv
        clr_mon();
        post(0, 2, 16'h9988);
        t = 0;
        while (dv_cyc_q.size() == 0 && t < 100) begin
            tick();
            t = t + 1;
            req_valid = req_valid & ~req_ready;
        end
        check("t7_dv_seen", dv_cyc_q.size() > 0, 1);
        tick();
        reset = 1'b1;
        tick();
        check("t7_busy", busy, 0);
        check("t7_tx", {m_if.m_tx_dv, m_if.m_tx_byte, m_if.m_tx_count}, 0);
        check("t7_rsp_data", rsp_rx_data, 0);
        check("t7_pulses", {req_ready, rsp_valid, rsp_err}, 0);
        check("t7_grant_id", grant_id, 0);
        reset = 1'b0;
        repeat (40) tick();
        check("t7_no_rsp", rsp_id_q.size(), 0);
        clr_mon();
        post(0, 1, 16'h007E);
        run(1, 200, "t7b");
        check("t7b_id", qget(rsp_id_q, 0), 0);
        check("t7b_err", qget(rsp_err_q, 0), 0);
        check("t7b_data", qget(rsp_dat_q, 0), 32'h007E);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
